uart_pid_frame_tx: RTL
======================

UART_PID_FRAME_TX -- requirements
Module: uart_pid_frame_tx

Interface
REQ-001 Parameters SHALL be: CLK_FREQ, default 50_000_000, system clock in Hz; BAUD_RATE, default 9600, line rate in bit/s.
REQ-002 Derived constant CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE (integer division); 5208 at defaults.
REQ-003 Port `clk`: input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-005 Port `a1`: input, 32 bits, first PID word to transmit.
REQ-006 Port `a2`: input, 32 bits, second PID word to transmit.
REQ-007 Port `send`: input, 1 bit, request to transmit one frame; sampled every cycle.
REQ-008 Port `tx`: output, 1 bit, UART serial line, 8N1, idle high.
REQ-009 Port `busy`: output, 1 bit, high while a frame is in progress.
REQ-010 Port `done`: output, 1 bit, one-cycle pulse when a frame completes.

Function
REQ-011 Frame SHALL be 10 bytes, in order: header 0xA5; a1[31:24], a1[23:16], a1[15:8], a1[7:0]; a2[31:24] .. a2[7:0]; checksum.
REQ-012 Checksum SHALL be the bitwise XOR of the 8 payload bytes; the header is excluded.
REQ-013 Each byte SHALL be sent as: start bit 0, data bits 0..7 (LSB first), stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-014 `send` SHALL be accepted only when `busy`=0; on acceptance, a1 and a2 SHALL be latched, and later input changes SHALL NOT affect the frame.
REQ-015 `send` while `busy`=1 SHALL be ignored and not queued.
REQ-016 `busy` SHALL rise on the cycle after acceptance and stay high until the `done` cycle.
REQ-017 The header start bit SHALL begin on `tx` exactly 2 cycles after the accepting edge.
REQ-018 Idle time between the stop bit of byte n and the start bit of byte n+1 SHALL be 0–2 cycles (`tx`=1 throughout).
REQ-019 The FSM SHALL have states IDLE, LOAD, SEND, NEXT, DONE.
  - IDLE -> LOAD on accepted `send`.
  - LOAD: present the byte at the current index to the serializer -> SEND.
  - SEND -> NEXT when the serializer reports the stop bit complete.
  - NEXT: if index=9 -> DONE; else increment index -> LOAD.
  - DONE: pulse `done` -> IDLE.
REQ-020 The byte index SHALL be 4 bits, range 0..9, and SHALL never wrap past 9.
REQ-021 The checksum SHALL accumulate during transmission or be computed at latch time; either way the transmitted value SHALL match REQ-012.
REQ-022 In the `done` cycle, `busy` SHALL be 0 and a `send` asserted in that cycle SHALL be accepted (back-to-back frames).
REQ-023 `tx` SHALL be 1 whenever the FSM is in IDLE or DONE.

Reset
REQ-024 While `rst`=1: FSM=IDLE, index=0, checksum=0, baud counter=0, `tx`=1, `busy`=0, `done`=0, latched words=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame: `tx`=1 from the edge where `rst` is sampled, with no `done` pulse.
REQ-026 `send` asserted while `rst`=1 SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold FRAME_HEADER (8'hA5), FRAME_BYTES (10), and the FSM state encoding.
REQ-028 One sub-module, uart_tx (8N1 byte serializer with inputs start/data and outputs tx/tx_busy/tx_done, parameterised by CLK_FREQ/BAUD_RATE), SHALL implement REQ-013.
REQ-029 The top-level module SHALL contain only the framing FSM, the latches and the checksum.

Verification (bench: CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16)
REQ-030 Basic frame: a1=0x12345678, a2=0xDEADBEEF, one-cycle `send` -> bytes A5 12 34 56 78 DE AD BE EF 2A decoded from `tx`; exactly one `done` pulse; frame length 1600–1618 cycles.
REQ-031 Input stability: change a1 to 0xFFFFFFFF one cycle after acceptance -> frame still carries 12 34 56 78.
REQ-032 Busy rejection: `send` pulsed at bytes 3 and 7 -> exactly one frame sent, one `done`, and `tx` idle afterwards.
REQ-033 Back-to-back: `send` held high continuously -> second header start bit begins 2 cycles after the first `done`.
REQ-034 Mid-frame reset: `rst` asserted for 1 cycle during byte 5 -> `tx`=1 from the next edge, `busy`=0, no `done`; a subsequent `send` yields a correct full frame.
REQ-035 Zero payload: a1=a2=0 -> bytes A5 00 00 00 00 00 00 00 00 00 (checksum 0x00).

Source files
------------

// File: rtl/uart_pid_frame_tx_pkg.sv
// Shared constants, FSM encoding and frame-assembly helpers for the PID frame transmitter.
package uart_pid_frame_tx_pkg;

    localparam logic [7:0]  FRAME_HEADER = 8'hA5;
    localparam int unsigned FRAME_BYTES  = 10;
    localparam int unsigned IDX_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [7:0]  chk;
    } frame_words_t;

    function automatic logic [7:0] payload_xor(input logic [31:0] w1, input logic [31:0] w2);
        return w1[31:24] ^ w1[23:16] ^ w1[15:8] ^ w1[7:0]
             ^ w2[31:24] ^ w2[23:16] ^ w2[15:8] ^ w2[7:0];
    endfunction

    // Byte on the wire at a given frame position: header, a1 MSB-first, a2 MSB-first, checksum.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input frame_words_t w);
        logic [7:0] b;
        case (idx)
            4'd0:    b = FRAME_HEADER;
            4'd1:    b = w.a1[31:24];
            4'd2:    b = w.a1[23:16];
            4'd3:    b = w.a1[15:8];
            4'd4:    b = w.a1[7:0];
            4'd5:    b = w.a2[31:24];
            4'd6:    b = w.a2[23:16];
            4'd7:    b = w.a2[15:8];
            4'd8:    b = w.a2[7:0];
            default: b = w.chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_pid_frame_tx_uart_tx.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nbit_q, nbit_d;
    logic [7:0]       sh_q, sh_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            cnt_q  <= '0;
            nbit_q <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            tx_q   <= tx_d;
            cnt_q  <= cnt_d;
            nbit_q <= nbit_d;
            sh_q   <= sh_d;
        end
    end

    // nbit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    always_comb begin
        busy_d = busy_q;
        tx_d   = tx_q;
        cnt_d  = cnt_q;
        nbit_d = nbit_q;
        sh_d   = sh_q;
        if (!busy_q) begin
            if (start) begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
                cnt_d  = '0;
                nbit_d = '0;
                sh_d   = data;
            end
        end else if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_d = '0;
            if (nbit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else if (nbit_q == 4'd8) begin
                tx_d   = 1'b1;
                nbit_d = 4'd9;
            end else begin
                tx_d   = sh_q[0];
                sh_d   = {1'b0, sh_q[7:1]};
                nbit_d = nbit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Reported two cycles before the stop bit ends so the framer can queue the next byte
    // without stretching the inter-byte gap.
    assign tx_done = busy_q && (nbit_q == 4'd9) && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: rtl/uart_pid_frame_tx.sv
// Frames two 32-bit PID words as header + 8 payload bytes + XOR checksum over a UART line.
module uart_pid_frame_tx
    import uart_pid_frame_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    frame_words_t     words_q, words_d;
    logic             start_q, start_d;
    logic [7:0]       byte_q, byte_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ser_busy;
    logic             ser_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            words_q <= '0;
            start_q <= 1'b0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            start_q <= start_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        start_d = 1'b0;
        byte_d  = byte_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE also accepts so that a held send yields back-to-back frames.
                state_d = ST_IDLE;
                if (send) begin
                    state_d     = ST_LOAD;
                    idx_d       = '0;
                    words_d.a1  = a1;
                    words_d.a2  = a2;
                    words_d.chk = payload_xor(a1, a2);
                end
            end
            ST_LOAD: begin
                if (!ser_busy) begin
                    start_d = 1'b1;
                    byte_d  = frame_byte(idx_q, words_q);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND) || (state_d == ST_NEXT);
    end

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_uart_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (start_q),
        .data   (byte_q),
        .tx     (tx),
        .tx_busy(ser_busy),
        .tx_done(ser_done)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
